// File: rtl/px_pkg.sv
// ---------------------------------------------------------------------------
// px_pkg
// Shared types and constants for the pixel readout buffer.
//   PX_DATA_W / PX_N_COLS / PX_N_ROWS : default frame geometry
//   pixel_t                           : one pixel code
//   bank_state_t                      : occupancy of one ping-pong bank
//   stream_state_t                    : output streamer state
//   idxWidth()                        : index width that stays >= 1 bit
// ---------------------------------------------------------------------------
package px_pkg;

    localparam int PX_DATA_W = 8;
    localparam int PX_N_COLS = 3;
    localparam int PX_N_ROWS = 3;

    typedef logic [PX_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // A geometry of one row/column would give $clog2() == 0, which would
    // make an illegal zero-width index port, so clamp to one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/px_frame_bank.sv
// ---------------------------------------------------------------------------
// px_frame_bank
// One N_ROWS x N_COLS frame store. A whole row is written at once (one column
// bus word per row); a single pixel is read combinationally.
//   i_clk      : clock
//   i_we       : write enable for row i_wr_row
//   i_wr_row   : row being written
//   i_wr_data  : all column codes of that row, col 0 in LSBs
//   i_rd_row   : row of the pixel being read
//   i_rd_col   : column of the pixel being read
//   o_rd_data  : selected pixel code
// ---------------------------------------------------------------------------
module px_frame_bank
    import px_pkg::*;
#(
    parameter int DATA_W = PX_DATA_W,
    parameter int N_COLS = PX_N_COLS,
    parameter int N_ROWS = PX_N_ROWS
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [idxWidth(N_ROWS)-1:0]   i_wr_row,
    input  logic [N_COLS*DATA_W-1:0]      i_wr_data,
    input  logic [idxWidth(N_ROWS)-1:0]   i_rd_row,
    input  logic [idxWidth(N_COLS)-1:0]   i_rd_col,
    output logic [DATA_W-1:0]             o_rd_data
);

    localparam int CW = idxWidth(N_COLS);

    logic [N_COLS*DATA_W-1:0] r_mem [N_ROWS];
    logic [N_COLS*DATA_W-1:0] w_rd_row;

    // Storage is deliberately not reset: a frame is only ever read after
    // every row of it has been written, so stale contents are never seen.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    assign w_rd_row = r_mem[i_rd_row];

    // Column select written as a compare loop so the index never has to be
    // multiplied up into a variable part-select base.
    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < N_COLS; c++) begin
            if (i_rd_col == CW'(c)) begin
                o_rd_data = w_rd_row[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/px_readout_buffer.sv
// ---------------------------------------------------------------------------
// px_readout_buffer
// Captures rows from the pixel array column buses into a ping-pong pair of
// frame banks and streams finished frames out in raster order.
//   i_clk        : clock, all state changes on posedge
//   i_rst_n      : asynchronous active-low reset
//   i_read       : readout strobe, column buses valid while high
//   i_row_sel    : row currently being read
//   i_col_data   : column buses, col 0 in LSBs
//   o_out_data   : streamed pixel code (0 when not valid)
//   o_out_valid  : beat valid
//   i_out_ready  : downstream accepts when valid && ready
//   o_out_first  : beat is pixel (0,0)
//   o_out_last   : beat is the final pixel of the frame
//   o_overrun    : sticky, a frame was dropped because both banks were busy
// ---------------------------------------------------------------------------
module px_readout_buffer
    import px_pkg::*;
#(
    parameter int DATA_W = PX_DATA_W,
    parameter int N_COLS = PX_N_COLS,
    parameter int N_ROWS = PX_N_ROWS
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_read,
    input  logic [idxWidth(N_ROWS)-1:0]   i_row_sel,
    input  logic [N_COLS*DATA_W-1:0]      i_col_data,
    output logic [DATA_W-1:0]             o_out_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_out_first,
    output logic                          o_out_last,
    output logic                          o_overrun
);

    localparam int              RW           = idxWidth(N_ROWS);
    localparam int              CW           = idxWidth(N_COLS);
    localparam logic [RW-1:0]   LAST_ROW     = RW'(N_ROWS - 1);
    localparam logic [CW-1:0]   LAST_COL     = CW'(N_COLS - 1);
    localparam logic            SINGLE_PIXEL = (N_ROWS * N_COLS == 1);

    // Write side
    logic                r_read_q;
    logic [RW-1:0]       r_row_sel_q;
    logic [N_ROWS-1:0]   r_row_done;
    logic                r_dropping;
    logic                r_wr_bank;
    logic                r_overrun;
    bank_state_t         r_bank_state [2];

    // Read side
    stream_state_t       r_state;
    logic                r_rd_bank;
    logic [RW-1:0]       r_rd_row;
    logic [CW-1:0]       r_rd_col;
    logic                r_valid;
    logic                r_first;
    logic                r_last;

    logic                w_wr_full;
    logic                w_rise;
    logic                w_fall;
    logic                w_commit;
    logic                w_capture;
    logic                w_accept;
    logic                w_beat_last;
    logic                w_release;
    logic                w_other_full;
    logic [RW-1:0]       w_next_row;
    logic [CW-1:0]       w_next_col;
    logic                w_next_last;
    logic [DATA_W-1:0]   w_bank0_data;
    logic [DATA_W-1:0]   w_bank1_data;

    assign w_wr_full    = (r_bank_state[r_wr_bank] == FULL);
    assign w_rise       = i_read && !r_read_q;
    assign w_fall       = !i_read && r_read_q;
    assign w_commit     = &r_row_done;
    // No write during the commit cycle: the bank being sealed must not change.
    assign w_capture    = i_read && !w_wr_full && !r_dropping && !w_commit;
    assign w_accept     = r_valid && i_out_ready;
    assign w_beat_last  = (r_rd_row == LAST_ROW) && (r_rd_col == LAST_COL);
    assign w_release    = w_accept && w_beat_last;
    assign w_other_full = (r_bank_state[~r_rd_bank] == FULL);

    // Raster successor of the current read position.
    always_comb begin
        w_next_row = r_rd_row;
        w_next_col = r_rd_col + 1'b1;
        if (r_rd_col == LAST_COL) begin
            w_next_col = '0;
            w_next_row = r_rd_row + 1'b1;
        end
    end

    assign w_next_last = (w_next_row == LAST_ROW) && (w_next_col == LAST_COL);

    px_frame_bank #(
        .DATA_W (DATA_W),
        .N_COLS (N_COLS),
        .N_ROWS (N_ROWS)
    ) u_bank0 (
        .i_clk     (i_clk),
        .i_we      (w_capture && !r_wr_bank),
        .i_wr_row  (i_row_sel),
        .i_wr_data (i_col_data),
        .i_rd_row  (r_rd_row),
        .i_rd_col  (r_rd_col),
        .o_rd_data (w_bank0_data)
    );

    px_frame_bank #(
        .DATA_W (DATA_W),
        .N_COLS (N_COLS),
        .N_ROWS (N_ROWS)
    ) u_bank1 (
        .i_clk     (i_clk),
        .i_we      (w_capture && r_wr_bank),
        .i_wr_row  (i_row_sel),
        .i_wr_data (i_col_data),
        .i_rd_row  (r_rd_row),
        .i_rd_col  (r_rd_col),
        .o_rd_data (w_bank1_data)
    );

    // Write-side bookkeeping: row completion mask, frame commit, drop mode
    // and the occupancy of both banks. Bank occupancy lives here alone so
    // that commit (write side) and release (read side) can land in the same
    // cycle; they always target different banks because only a FULL bank
    // is released and only a non-FULL bank is committed.
    // A dropped frame still tracks its row mask so that the drop ends at the
    // frame boundary rather than halfway through a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_read_q        <= 1'b0;
            r_row_sel_q     <= '0;
            r_row_done      <= '0;
            r_dropping      <= 1'b0;
            r_wr_bank       <= 1'b0;
            r_overrun       <= 1'b0;
            r_bank_state[0] <= EMPTY;
            r_bank_state[1] <= EMPTY;
        end else begin
            r_read_q <= i_read;
            if (i_read) begin
                r_row_sel_q <= i_row_sel;
            end

            if (w_commit) begin
                r_row_done <= '0;
                r_dropping <= 1'b0;
                if (!r_dropping) begin
                    r_bank_state[r_wr_bank] <= FULL;
                    r_wr_bank               <= ~r_wr_bank;
                end
            end else if (w_fall) begin
                r_row_done[r_row_sel_q] <= 1'b1;
            end

            if (w_rise && w_wr_full) begin
                r_dropping <= 1'b1;
                r_overrun  <= 1'b1;
            end

            if (w_capture && (r_bank_state[r_wr_bank] == EMPTY)) begin
                r_bank_state[r_wr_bank] <= FILLING;
            end

            if (w_release) begin
                r_bank_state[r_rd_bank] <= EMPTY;
            end
        end
    end

    // Output streamer. Valid/first/last are registered and only advance on
    // an accepted beat, so out_ready never reaches out_valid combinationally
    // and everything is held steady during a stall. When the other bank is
    // already FULL at the final beat, it is picked up with no idle cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_valid   <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_bank_state[r_rd_bank] == FULL) begin
                        r_state  <= STREAM;
                        r_rd_row <= '0;
                        r_rd_col <= '0;
                        r_valid  <= 1'b1;
                        r_first  <= 1'b1;
                        r_last   <= SINGLE_PIXEL;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (w_beat_last) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_rd_row  <= '0;
                            r_rd_col  <= '0;
                            if (w_other_full) begin
                                r_first <= 1'b1;
                                r_last  <= SINGLE_PIXEL;
                            end else begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_first <= 1'b0;
                                r_last  <= 1'b0;
                            end
                        end else begin
                            r_rd_row <= w_next_row;
                            r_rd_col <= w_next_col;
                            r_first  <= 1'b0;
                            r_last   <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_data  = r_valid ? (r_rd_bank ? w_bank1_data : w_bank0_data) : '0;
    assign o_out_valid = r_valid;
    assign o_out_first = r_first;
    assign o_out_last  = r_last;
    assign o_overrun   = r_overrun;

endmodule
